// File: rtl/mem_access_ctrl.sv
// Byte-serial memory access controller: arbitrates IF fetches and MEM loads/stores onto a
// byte-wide synchronous RAM. Define MAC_ALIGN_CHECK_EN to reject misaligned MEM accesses.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_inst,
  output logic        if_done,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [1:0]  mem_width,
  input  logic        mem_signed,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        mem_err,
  output logic [31:0] ram_addr,
  output logic        ram_wr,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  output logic        if_stall_req,
  output logic        mem_stall_req
);

`ifdef MAC_ALIGN_CHECK_EN
  localparam bit AlignCheck = 1'b1;
`else
  localparam bit AlignCheck = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic [1:0]  width_q, width_d;
  logic        is_mem_q, is_mem_d;
  logic        is_wr_q, is_wr_d;
  logic        signed_q, signed_d;
  logic        err_q, err_d;

  logic        mem_req;
  logic        misaligned;
  logic [2:0]  last_cnt;
  logic [1:0]  rd_idx;

  function automatic logic [2:0] width_bytes(input logic [1:0] w);
    unique case (w)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] b, input logic [1:0] w,
                                         input logic s);
    unique case (w)
      2'd0:    return s ? {{24{b[7]}}, b[7:0]} : {24'd0, b[7:0]};
      2'd1:    return s ? {{16{b[15]}}, b[15:0]} : {16'd0, b[15:0]};
      default: return b;
    endcase
  endfunction

  assign mem_req    = mem_rd | mem_wr;
  assign misaligned = AlignCheck &&
                      (((mem_width == 2'd1) && mem_addr[0]) ||
                       (mem_width[1] && (mem_addr[1:0] != 2'd0)));
  // Reads need one extra cycle to capture the last byte behind the RAM latency.
  assign last_cnt   = is_wr_q ? (nbytes_q - 3'd1) : nbytes_q;
  assign rd_idx     = 2'(cnt_q - 3'd1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nbytes_d    = nbytes_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    width_d     = width_q;
    is_mem_d    = is_mem_q;
    is_wr_d     = is_wr_q;
    signed_d    = signed_q;
    err_d       = err_q;
    ram_addr    = 32'd0;
    ram_wr      = 1'b0;
    ram_din     = 8'd0;

    unique case (state_q)
      StIdle: begin
        if (mem_req) begin
          base_d   = mem_addr;
          wdata_d  = mem_wdata;
          width_d  = mem_width;
          signed_d = mem_signed;
          nbytes_d = width_bytes(mem_width);
          is_mem_d = 1'b1;
          is_wr_d  = mem_wr;
          cnt_d    = 3'd0;
          buf_d    = 32'd0;
          err_d    = misaligned;
          state_d  = misaligned ? StDone : StBusy;
        end else if (if_req) begin
          base_d   = if_addr;
          nbytes_d = 3'd4;
          is_mem_d = 1'b0;
          is_wr_d  = 1'b0;
          cnt_d    = 3'd0;
          buf_d    = 32'd0;
          err_d    = 1'b0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q < nbytes_q) begin
          ram_addr = base_q + 32'(cnt_q);
          ram_wr   = is_wr_q;
          if (is_wr_q) ram_din = wdata_q[8*cnt_q[1:0] +: 8];
        end
        if (!is_wr_q && (cnt_q != 3'd0)) buf_d[8*rd_idx +: 8] = ram_dout;
        if (cnt_q == last_cnt) begin
          state_d = StDone;
          cnt_d   = 3'd0;
          if (!is_wr_q) begin
            if (is_mem_q) mem_rdata_d = extend(buf_d, width_q, signed_q);
            else          if_inst_d   = buf_d;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      nbytes_q    <= 3'd0;
      base_q      <= 32'd0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      if_inst_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
      width_q     <= 2'd0;
      is_mem_q    <= 1'b0;
      is_wr_q     <= 1'b0;
      signed_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nbytes_q    <= nbytes_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
      width_q     <= width_d;
      is_mem_q    <= is_mem_d;
      is_wr_q     <= is_wr_d;
      signed_q    <= signed_d;
      err_q       <= err_d;
    end
  end

  assign if_inst       = if_inst_q;
  assign mem_rdata     = mem_rdata_q;
  assign if_done       = (state_q == StDone) && !is_mem_q;
  assign mem_done      = (state_q == StDone) && is_mem_q && !err_q;
  assign mem_err       = (state_q == StDone) && is_mem_q && err_q;
  assign if_stall_req  = if_req & ~if_done;
  assign mem_stall_req = mem_req & ~mem_done & ~mem_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a byte-wide synchronous RAM model.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        if_done;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_width;
  logic        mem_signed;
  logic [31:0] mem_rdata;
  logic        mem_done, mem_err;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic        if_stall_req, mem_stall_req;

  logic [7:0]  ram [0:4095];
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [7:0]  pl_data;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (ram_wr) ram[ram_addr[11:0]] <= ram_din;
    ram_dout <= ram[ram_addr[11:0]];
  end

  mem_access_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_inst      (if_inst),
    .if_done      (if_done),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_width    (mem_width),
    .mem_signed   (mem_signed),
    .mem_rdata    (mem_rdata),
    .mem_done     (mem_done),
    .mem_err      (mem_err),
    .ram_addr     (ram_addr),
    .ram_wr       (ram_wr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout),
    .if_stall_req (if_stall_req),
    .mem_stall_req(mem_stall_req)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic mem_req(input logic rd, input logic [31:0] a, input logic [1:0] w,
                         input logic s, input logic [31:0] wd);
    mem_rd     = rd;
    mem_wr     = ~rd;
    mem_addr   = a;
    mem_width  = w;
    mem_signed = s;
    mem_wdata  = wd;
  endtask

  task automatic mem_release();
    mem_rd = 1'b0;
    mem_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_width = '0;
    mem_signed = 1'b0;
    tick();
    poke(12'h100, 8'h78); poke(12'h101, 8'h56); poke(12'h102, 8'h34); poke(12'h103, 8'h12);
    poke(12'h104, 8'h9A); poke(12'h010, 8'h80); poke(12'h201, 8'h11); poke(12'h202, 8'h00);
    poke(12'h203, 8'h00); poke(12'h204, 8'h22);

    // Reset state
    chk("rst_mem_done", 32'(mem_done), 32'd0);
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_din", 32'(ram_din), 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    rst = 1'b0;
    tick();

    // LW 0x100
    mem_req(1'b1, 32'h100, 2'd2, 1'b0, 32'd0);
    #1;
    chk("lw_stall_pending", 32'(mem_stall_req), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("lw_ram_addr", ram_addr, 32'h100 + 32'(k));
      chk("lw_ram_wr", 32'(ram_wr), 32'd0);
      chk("lw_no_done", 32'(mem_done), 32'd0);
    end
    tick();
    chk("lw_no_done_cap", 32'(mem_done), 32'd0);
    tick();
    chk("lw_done", 32'(mem_done), 32'd1);
    chk("lw_rdata", mem_rdata, 32'h12345678);
    chk("lw_stall_drop", 32'(mem_stall_req), 32'd0);
    chk("lw_done_addr0", ram_addr, 32'd0);
    mem_release();
    tick();
    chk("lw_done_pulse", 32'(mem_done), 32'd0);
    chk("lw_rdata_held", mem_rdata, 32'h12345678);

    // LB signed / unsigned at 0x10
    mem_req(1'b1, 32'h10, 2'd0, 1'b1, 32'd0);
    tick();
    chk("lbs_ram_addr", ram_addr, 32'h10);
    tick();
    tick();
    chk("lbs_done", 32'(mem_done), 32'd1);
    chk("lbs_rdata", mem_rdata, 32'hFFFFFF80);
    mem_release();
    tick();
    mem_req(1'b1, 32'h10, 2'd0, 1'b0, 32'd0);
    tick();
    tick();
    tick();
    chk("lbu_done", 32'(mem_done), 32'd1);
    chk("lbu_rdata", mem_rdata, 32'h00000080);
    mem_release();
    tick();

    // SH 0xBEEF to 0x202
    mem_req(1'b0, 32'h202, 2'd1, 1'b0, 32'h1234BEEF);
    tick();
    chk("sh_addr0", ram_addr, 32'h202);
    chk("sh_wr0", 32'(ram_wr), 32'd1);
    chk("sh_din0", 32'(ram_din), 32'hEF);
    tick();
    chk("sh_addr1", ram_addr, 32'h203);
    chk("sh_wr1", 32'(ram_wr), 32'd1);
    chk("sh_din1", 32'(ram_din), 32'hBE);
    tick();
    chk("sh_done", 32'(mem_done), 32'd1);
    chk("sh_wr_off", 32'(ram_wr), 32'd0);
    mem_release();
    tick();
    chk("sh_ram_201", 32'(ram[12'h201]), 32'h11);
    chk("sh_ram_202", 32'(ram[12'h202]), 32'hEF);
    chk("sh_ram_203", 32'(ram[12'h203]), 32'hBE);
    chk("sh_ram_204", 32'(ram[12'h204]), 32'h22);

    // Simultaneous IF and MEM requests: MEM wins
    if_req = 1'b1; if_addr = 32'h100;
    mem_req(1'b1, 32'h10, 2'd0, 1'b0, 32'd0);
    #1;
    chk("arb_if_stall", 32'(if_stall_req), 32'd1);
    chk("arb_mem_stall", 32'(mem_stall_req), 32'd1);
    tick();
    chk("arb_mem_first", ram_addr, 32'h10);
    tick();
    tick();
    chk("arb_mem_done", 32'(mem_done), 32'd1);
    chk("arb_if_not_done", 32'(if_done), 32'd0);
    chk("arb_mem_stall_drop", 32'(mem_stall_req), 32'd0);
    chk("arb_if_stall_held", 32'(if_stall_req), 32'd1);
    mem_release();
    tick();
    chk("arb_idle_no_if_done", 32'(if_done), 32'd0);
    tick();
    chk("arb_if_addr0", ram_addr, 32'h100);
    for (int k = 0; k < 4; k++) tick();
    chk("arb_if_pre_done", 32'(if_done), 32'd0);
    tick();
    chk("arb_if_done", 32'(if_done), 32'd1);
    chk("arb_if_inst", if_inst, 32'h12345678);
    chk("arb_if_stall_drop", 32'(if_stall_req), 32'd0);
    chk("arb_if_mem_done0", 32'(mem_done), 32'd0);
    chk("arb_mem_rdata_held", mem_rdata, 32'h00000080);
    if_req = 1'b0;
    tick();

    // Reset in second BUSY cycle of LW, request held and re-issued
    mem_req(1'b1, 32'h100, 2'd2, 1'b0, 32'd0);
    tick();
    tick();
    chk("rstmid_busy1", ram_addr, 32'h101);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_no_done", 32'(mem_done), 32'd0);
    chk("rstmid_ram_wr", 32'(ram_wr), 32'd0);
    chk("rstmid_ram_addr", ram_addr, 32'd0);
    chk("rstmid_rdata", mem_rdata, 32'd0);
    chk("rstmid_if_inst", if_inst, 32'd0);
    tick();
    chk("rstmid_reissue", ram_addr, 32'h100);
    for (int k = 0; k < 4; k++) tick();
    chk("rstmid_pre_done", 32'(mem_done), 32'd0);
    tick();
    chk("rstmid_done", 32'(mem_done), 32'd1);
    chk("rstmid_rdata2", mem_rdata, 32'h12345678);
    mem_release();
    tick();

    // Misaligned LW at 0x101
    mem_req(1'b1, 32'h101, 2'd2, 1'b0, 32'd0);
`ifdef MAC_ALIGN_CHECK_EN
    tick();
    chk("mis_err", 32'(mem_err), 32'd1);
    chk("mis_no_done", 32'(mem_done), 32'd0);
    chk("mis_no_ram", 32'(ram_wr), 32'd0);
    chk("mis_ram_addr", ram_addr, 32'd0);
    chk("mis_rdata_kept", mem_rdata, 32'h12345678);
    chk("mis_stall_drop", 32'(mem_stall_req), 32'd0);
`else
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mis_ram_addr", ram_addr, 32'h101 + 32'(k));
    end
    tick();
    tick();
    chk("mis_done", 32'(mem_done), 32'd1);
    chk("mis_err0", 32'(mem_err), 32'd0);
    chk("mis_rdata", mem_rdata, 32'h9A123456);
`endif
    mem_release();
    tick();
    chk("mis_err_pulse", 32'(mem_err), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
